// File: rtl/debug_uart_tx_if.sv
// Handshake and data bundle between the debug-port source and the UART transmitter.
// Master drives start and the port snapshot; slave returns the serial line and status.
interface debug_uart_tx_if;
    logic       start;
    logic [7:0] debug_port1;
    logic [7:0] debug_port2;
    logic [7:0] debug_port3;
    logic [7:0] debug_port4;
    logic [7:0] debug_port5;
    logic [7:0] debug_port6;
    logic [7:0] debug_port7;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output debug_port1, debug_port2, debug_port3, debug_port4,
        output debug_port5, debug_port6, debug_port7,
        input  tx, busy, done
    );

    modport slave (
        input  start,
        input  debug_port1, debug_port2, debug_port3, debug_port4,
        input  debug_port5, debug_port6, debug_port7,
        output tx, busy, done
    );
endinterface

// File: rtl/debug_uart_tx.sv
// 8N1 UART transmitter framing a snapshot of the seven debug ports:
// sync byte, seven port bytes, XOR checksum of the port bytes.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned NUM_PORTS    = 7
) (
    input  logic           clk,
    input  logic           nreset,
    debug_uart_tx_if.slave bus
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BYTE = 4'(NUM_PORTS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [3:0]                byte_q, byte_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [NUM_PORTS-1:0][7:0] snap_q;
    logic [7:0]                csum_q;

    logic [NUM_PORTS-1:0][7:0] ports;
    logic [7:0]                ports_xor;
    logic [7:0]                cur_byte;
    logic [2:0]                bit_nxt;
    logic                      accept;
    logic                      bit_end;

    assign ports = {bus.debug_port7, bus.debug_port6, bus.debug_port5, bus.debug_port4,
                    bus.debug_port3, bus.debug_port2, bus.debug_port1};

    always_comb begin
        ports_xor = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ports_xor = ports_xor ^ ports[i];
        end
    end

    assign accept  = !busy_q && bus.start;
    assign bit_end = (cnt_q == CNT_LAST);
    assign bit_nxt = bit_q + 3'd1;

    // Byte 0 is the sync pattern, the last byte is the checksum, the rest come from the snapshot.
    always_comb begin
        cur_byte = SYNC_BYTE;
        if (byte_q == LAST_BYTE) begin
            cur_byte = csum_q;
        end else if (byte_q != 4'd0) begin
            cur_byte = snap_q[3'(byte_q - 4'd1)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = START;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        byte_d  = '0;
                        tx_d    = 1'b1;
                    end else begin
                        // Next byte's start bit follows the stop bit with no idle gap.
                        byte_d  = byte_q + 4'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Ports are frozen on the accepting edge so the frame is a coherent snapshot.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            snap_q <= '0;
            csum_q <= '0;
        end else if (accept) begin
            snap_q <= ports;
            csum_q <= ports_xor;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: table vectors, random snapshots against a line-level model,
// and hand sequences for busy-ignore, back-to-back and mid-frame reset.
module tb_debug_uart_tx;
    localparam int CPB       = 4;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = 90 * CPB;

    typedef logic [6:0][7:0] ports_t;
    typedef logic [8:0][7:0] frame_t;
    typedef struct {
        ports_t ports;
        frame_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic nreset;

    debug_uart_tx_if bus();

    debug_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5),
        .NUM_PORTS   (7)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ones_run = 0;
    int last_gap = 0;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic ports_t mkp(input logic [7:0] a, b, c, d, e, f, g);
        ports_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f; r[6] = g;
        return r;
    endfunction

    function automatic frame_t mkf(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8);
        frame_t r;
        r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3; r[4] = b4;
        r[5] = b5; r[6] = b6; r[7] = b7; r[8] = b8;
        return r;
    endfunction

    // Reference frame: sync, the ports in order, XOR of the ports.
    function automatic frame_t model_frame(input ports_t p);
        frame_t     f;
        logic [7:0] cs = 8'h00;
        f[0] = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            f[i+1] = p[i];
            cs     = cs ^ p[i];
        end
        f[8] = cs;
        return f;
    endfunction

    // Expected line level k cycles after the accept edge: 10 slots per byte, CPB cycles per slot.
    function automatic logic exp_tx(input frame_t f, input int k);
        int b = k / BYTE_CYC;
        int s = (k % BYTE_CYC) / CPB;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return f[b][s-1];
    endfunction

    function automatic ports_t rand_ports();
        ports_t p;
        for (int i = 0; i < 7; i++) p[i] = 8'($urandom_range(0, 255));
        return p;
    endfunction

    task automatic drive_ports(input ports_t p);
        bus.debug_port1 = p[0];
        bus.debug_port2 = p[1];
        bus.debug_port3 = p[2];
        bus.debug_port4 = p[3];
        bus.debug_port5 = p[4];
        bus.debug_port6 = p[5];
        bus.debug_port7 = p[6];
    endtask

    task automatic sample();
        @(negedge clk);
        if (bus.tx === 1'b1) begin
            ones_run++;
        end else begin
            last_gap = ones_run;
            ones_run = 0;
        end
    endtask

    // Entered just before the negedge that follows the accept edge; returns at the done-cycle negedge.
    task automatic check_frame(input string name, input frame_t f, input ports_t after,
                               input bit release_start, input int pulse_at, input bit gap_chk);
        frame_t dec      = '0;
        int     mism     = 0;
        int     busy_cnt = 0;
        int     done_cnt = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            sample();
            if (k == 0) begin
                if (release_start) bus.start = 1'b0;
                drive_ports(after);
                if (gap_chk) check($sformatf("%s_gap", name), last_gap, 5);
            end
            if (pulse_at >= 0 && k == pulse_at)     bus.start = 1'b1;
            if (pulse_at >= 0 && k == pulse_at + 1) bus.start = 1'b0;
            if (bus.tx !== exp_tx(f, k)) mism++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done !== 1'b0) done_cnt++;
            if (k % CPB == CPB / 2) begin
                int b = k / BYTE_CYC;
                int s = (k % BYTE_CYC) / CPB;
                if (s >= 1 && s <= 8) dec[b][s-1] = bus.tx;
            end
        end
        check($sformatf("%s_wave", name), mism, 0);
        check($sformatf("%s_busy_len", name), busy_cnt, FRAME_CYC);
        check($sformatf("%s_done_early", name), done_cnt, 0);
        for (int b = 0; b < 9; b++) begin
            check($sformatf("%s_byte%0d", name, b), dec[b], f[b]);
        end
        sample();
        check($sformatf("%s_done", name), bus.done, 1);
        check($sformatf("%s_busy_end", name), bus.busy, 0);
        check($sformatf("%s_tx_end", name), bus.tx, 1);
    endtask

    task automatic idle_check(input string name, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            sample();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic send(input string name, input ports_t p, input frame_t f, input int pulse_at);
        drive_ports(p);
        bus.start = 1'b1;
        check_frame(name, f, rand_ports(), 1'b1, pulse_at, 1'b0);
    endtask

    initial begin
        ports_t p;
        ports_t q;
        int     mism;
        int     bad;

        vecs[0] = '{mkp(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40),
                    mkf(8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h7F)};
        vecs[1] = '{mkp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00),
                    mkf(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00)};
        vecs[2] = '{mkp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF),
                    mkf(8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
        vecs[3] = '{mkp(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE),
                    mkf(8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0)};
        vecs[4] = '{mkp(8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02),
                    mkf(8'hA5, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'hFE)};

        nreset    = 1'b0;
        bus.start = 1'b0;
        drive_ports('0);
        #12;
        check("reset_tx", bus.tx, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        @(negedge clk);
        nreset = 1'b1;
        idle_check("idle_after_reset", 50);

        for (int i = 0; i < 5; i++) begin
            send($sformatf("vec%0d", i), vecs[i].ports, vecs[i].exp, -1);
            idle_check($sformatf("vec%0d_idle", i), 3);
        end

        // Ports change to FF right after the accept edge; the frame must carry 3C.
        drive_ports(mkp(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C));
        bus.start = 1'b1;
        check_frame("snap", mkf(8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C),
                    mkp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1, -1, 1'b0);
        idle_check("snap_idle", 3);

        send("ignore", vecs[3].ports, vecs[3].exp, 50);
        idle_check("ignore_idle", 2 * BYTE_CYC);

        for (int r = 0; r < 6; r++) begin
            p = rand_ports();
            send($sformatf("rnd%0d", r), p, model_frame(p), -1);
            idle_check($sformatf("rnd%0d_idle", r), 2);
        end

        // start held high: second frame snapshots the ports present at the done cycle.
        q = rand_ports();
        drive_ports(vecs[0].ports);
        bus.start = 1'b1;
        check_frame("b2b1", vecs[0].exp, q, 1'b0, -1, 1'b0);
        check_frame("b2b2", model_frame(q), rand_ports(), 1'b1, -1, 1'b1);
        idle_check("b2b_idle", 3);

        // Reset during byte 3, data bit 5 (a zero bit, so the jump to idle-high is visible).
        p = rand_ports();
        p[2] = p[2] & 8'hDF;
        drive_ports(p);
        bus.start = 1'b1;
        mism = 0;
        for (int k = 0; k <= 3 * BYTE_CYC + 6 * CPB + 2; k++) begin
            sample();
            if (k == 0) bus.start = 1'b0;
            if (bus.tx !== exp_tx(model_frame(p), k)) mism++;
        end
        check("mr_pre_wave", mism, 0);
        #2;
        nreset = 1'b0;
        #1;
        check("mr_tx", bus.tx, 1);
        check("mr_busy", bus.busy, 0);
        check("mr_done", bus.done, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (bus.done !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        check("mr_hold", bad, 0);
        nreset = 1'b1;
        idle_check("mr_idle", 20);
        p = rand_ports();
        send("mr_after", p, model_frame(p), -1);
        idle_check("mr_after_idle", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
Serialises a snapshot of the CPU's seven 8-bit debug ports to the host serial-port debugger over a single UART TX line (8N1, LSB first). It is the transmit end of the debug link: the CPU drives debug_port1..7 and this block frames them for the host-side receiver. A frame is a sync byte, the seven port bytes in order, and an XOR checksum byte. It sits beside the cpu at top level; its tx output goes to the board's serial pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal minimum 2
SYNC_BYTE, 8'hA5, first byte of every frame
NUM_PORTS, 7, number of debug bytes per frame; fixed at 7 for this revision

Ports:
clk  input  1  system clock, rising-edge
nreset  input  1  asynchronous active-low reset
start  input  1  request one frame; sampled on clk rising edge
debug_port1  input  8  frame byte 1
debug_port2  input  8  frame byte 2
debug_port3  input  8  frame byte 3
debug_port4  input  8  frame byte 4
debug_port5  input  8  frame byte 5
debug_port6  input  8  frame byte 6
debug_port7  input  8  frame byte 7
tx  output  1  UART line; idle high
busy  output  1  high while a frame is in flight
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (nreset low, async): tx=1, busy=0, done=0, state=IDLE, byte index=0, bit counter=0, snapshot registers=0. Release is synchronous to clk.
- All outputs are registered; no combinational path from inputs to outputs.
- Accept rule: start is accepted at a rising edge iff busy==0 before that edge. While busy, start is ignored with no queueing.
- On accept, the same edge captures debug_port1..7 into the snapshot registers and computes checksum = XOR of the 7 bytes (SYNC_BYTE is excluded). Port changes after that edge do not affect the frame. The same edge sets busy=1 and enters START with tx=0.
- Frame byte order: 0=SYNC_BYTE, 1..7=debug_port1..7, 8=checksum. Total 9 bytes.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1; on accept -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA with bit index 0.
  - DATA: tx = current byte[bit index]; each bit lasts CLKS_PER_BIT cycles; after bit 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index < 8, increment it and go to START with no idle gap. If byte index == 8, go to IDLE.
- Byte length is 10*CLKS_PER_BIT cycles; frame length is exactly 90*CLKS_PER_BIT cycles, from the accept edge to the edge that ends the last stop bit.
- Completion: the edge that ends the final stop bit sets busy=0, done=1, and byte index=0. done drops on the next edge.
- A start that is high during the done cycle is accepted on the next edge. This gives back-to-back frames with the line held high for exactly 1 cycle between them.
- Bit counter wraps from CLKS_PER_BIT-1 to 0. Its width is $clog2(CLKS_PER_BIT).
- Reset mid-frame: tx returns high immediately and the frame is abandoned. No done pulse is produced. The host receiver resynchronises on SYNC_BYTE.
- start held high continuously: a new frame is sent after each completion, each with a fresh snapshot.

Test Plan:
- Reset: assert nreset=0 mid-stream -> tx=1, busy=0, done=0 immediately (async). Hold start=0 after release -> tx stays 1 indefinitely.
- Single frame, CLKS_PER_BIT=4, ports = 01,02,04,08,10,20,40, pulse start -> bench UART model decodes A5 01 02 04 08 10 20 40 7F. busy is high for exactly 360 cycles. done pulses once, on the cycle busy falls.
- Snapshot: start with all ports = 8'h3C, then change all ports to 8'hFF on the next cycle -> frame is A5, seven bytes of 3C, checksum 3C (XOR of seven 3C).
- Busy ignore: pulse start again 50 cycles into a frame -> exactly one frame is sent and done pulses exactly once.
- Back-to-back: hold start=1 for two frames (CLKS_PER_BIT=4) -> two complete frames. tx is high for exactly 5 cycles between the start of the last stop bit and the next start bit (4 stop + 1 accept gap).
- Mid-frame reset: assert nreset low during byte 3, data bit 5 -> tx=1 at once, no done pulse. After release, a new start produces a clean, correct frame.
